ibex_irq_ctrl: RTL and testbench
================================

# ibex_irq_ctrl

Interrupt capture, prioritisation and request block that sits between the core's interrupt inputs and the ID-stage controller. It registers the `irqs_t` sources into the `mip` view and edge-detects the non-maskable interrupt. Each cycle it selects the highest-priority enabled pending interrupt and presents it to the controller as a stable request/cause pair. The request is held until the controller acknowledges it by taking the trap. The block also tracks NMI-handler occupancy and provides a WFI wake signal.

## Interface
- `NmiEdge`, default 1: 1 = NMI is rising-edge triggered and sticky until acknowledged; 0 = NMI is level-sensitive.
- `clk_i` in, 1: core clock.
- `rst_ni` in, 1: asynchronous, active-low reset.
- `irqs_i` in, `irqs_t` (18): software, timer, external and fast[14:0] levels.
- `irq_nm_i` in, 1: non-maskable interrupt.
- `mie_i` in, `irqs_t`: enable mask, already repacked from `mie` using `CSR_MSIX_BIT`, `CSR_MTIX_BIT`, `CSR_MEIX_BIT` and `CSR_MFIX_BIT_LOW..HIGH`.
- `mstatus_mie_i` in, 1: global M-mode enable.
- `priv_lvl_i` in, `priv_lvl_e`: current privilege level.
- `debug_mode_i` in, 1: core is in debug mode.
- `irq_ack_i` in, 1: controller takes the presented interrupt this cycle.
- `nmi_mret_i` in, 1: MRET retired from the NMI handler.
- `irq_req_o` out, 1: interrupt request, registered.
- `irq_cause_o` out, 6: `exc_cause_e` encoding, registered. Fast n encodes as {1, 16+n}; NMI encodes as `EXC_CAUSE_IRQ_NM`.
- `mip_o` out, `irqs_t`: registered pending sources.
- `irq_wake_o` out, 1: pending & enabled, or NMI pending. Ignores `mstatus.MIE`; used for WFI wake.
- `nmi_mode_o` out, 1: NMI handler active.

## Operation
- `mip_q` <= `irqs_i` every cycle. `nm_q` <= `irq_nm_i`.
- NMI pending, `NmiEdge`=1:
  - `nmi_pend_q` is set on `irq_nm_i & ~nm_q`.
  - It is cleared on ack while `irq_cause_o == EXC_CAUSE_IRQ_NM`.
  - Set and clear in the same cycle: set wins.
- NMI pending, `NmiEdge`=0: `nmi_pend = nm_q`.
- Gating:
  - `global_en = (mstatus_mie_i | priv_lvl_i != PRIV_LVL_M) & ~debug_mode_i`.
  - `en = mip_q & mie_i`.
  - NMI is eligible when `~debug_mode_i`.
- Priority, highest first: NMI, fast[0] .. fast[14], external, software, timer.
- FSM states: `IRQ_IDLE`, `IRQ_REQ`, `IRQ_NMI`.
  - `IRQ_IDLE` -> `IRQ_REQ` when an eligible candidate exists. NMI is always eligible; others require `global_en`. `irq_req_o` <= 1 and `irq_cause_o` <= the winner.
  - `IRQ_REQ`: request and cause are frozen. A later higher-priority arrival does not change the cause.
  - `IRQ_REQ`, `irq_ack_i`: go to `IRQ_NMI` if the cause is NMI, else to `IRQ_IDLE`. `irq_req_o` <= 0.
  - `IRQ_REQ` with a maskable cause, and `global_en` falls or its `en` bit clears, without ack: go to `IRQ_IDLE` and drop the request (withdrawal).
  - `IRQ_REQ` with an NMI cause: never withdrawn except by reset.
  - `IRQ_NMI`: no requests of any kind. `nmi_mode_o` = 1. On `nmi_mret_i` go to `IRQ_IDLE`.
- `irq_ack_i` outside `IRQ_REQ` is ignored and flagged by an assertion.
- Reset values:
  - `irq_req_o` = 0, `irq_cause_o` = 0, `mip_o` = 0, `nmi_mode_o` = 0.
  - `irq_wake_o` = 0, since it is derived from the reset registers.
  - FSM = `IRQ_IDLE`, `nmi_pend_q` = 0, `nm_q` = 0.
- Reset mid-request drops everything asynchronously. A pending NMI edge is lost.

## Timing
- Source rises in cycle N: `mip_o` high at N+1, `irq_req_o` high at N+2.
- `irq_wake_o` is combinational from registered state: high at N+1.
- Ack in cycle M: `irq_req_o` low at M+1. The next request is earliest at M+2, giving at least one low cycle between requests.
- Withdrawal condition in cycle W: request low at W+1.
- `nmi_mret_i` in cycle R: FSM in `IRQ_IDLE` at R+1; a new request earliest at R+2.
- `irq_cause_o` is stable for every cycle that `irq_req_o` is high.

## Structure
- Add to `ibex_pkg`:
  - `irq_ctrl_state_e` (2-bit).
  - `EXC_CAUSE_IRQ_FAST_0 = {1'b1, 5'd16}`.
  - Function `irq_fast_cause(idx)`.
- Sub-module `ibex_irq_prio_enc`: combinational. Inputs are the eligible vector plus NMI; outputs are `valid` and a 6-bit cause. Reusable by the CSR block for `mcause` checks.
- The FSM, NMI edge logic and output registers live in `ibex_irq_ctrl`.

## Test plan
- Timer only, `mie.MTIE`=1, `mstatus.MIE`=1, M-mode:
  - `irq_req_o` rises 2 cycles after the source, cause 0x27.
  - Ack -> request low next cycle.
- fast[3] and external asserted in the same cycle:
  - Cause 0x33 (fast 3) is presented.
  - After ack, with external still high, cause 0x2B after one idle cycle.
- Request pending with cause 0x2B; fast[0] then rises:
  - Cause stays 0x2B until ack.
  - Clearing `mstatus.MIE` before ack drops the request one cycle later.
- NMI pulse of 1 cycle (`NmiEdge`=1) while `mstatus.MIE`=0:
  - Cause 0x3F is requested.
  - After ack, `nmi_mode_o`=1 and timer pending produces no request until `nmi_mret_i`.
  - The timer request (cause 0x27) then appears 2 cycles after `nmi_mret_i`.
- `debug_mode_i`=1 with NMI and software pending: no request.
- WFI case: `mstatus.MIE`=0 with software pending and enabled gives `irq_wake_o`=1 and `irq_req_o`=0.
- `rst_ni` low while `irq_req_o`=1 and NMI pending: all outputs 0 immediately; no request after release.

Source files
------------

// File: rtl/ibex_irq_ctrl_pkg.sv
// ibex_irq_ctrl_pkg: interrupt source layout, cause encodings and controller state type.
package ibex_irq_ctrl_pkg;
  typedef struct packed {
    logic        irq_software;
    logic        irq_timer;
    logic        irq_external;
    logic [14:0] irq_fast;
  } irqs_t;
  typedef enum logic [1:0] {
    PRIV_LVL_U = 2'b00,
    PRIV_LVL_S = 2'b01,
    PRIV_LVL_H = 2'b10,
    PRIV_LVL_M = 2'b11
  } priv_lvl_e;
  typedef enum logic [5:0] {
    EXC_CAUSE_IRQ_SOFTWARE_M = {1'b1, 5'd3},
    EXC_CAUSE_IRQ_TIMER_M    = {1'b1, 5'd7},
    EXC_CAUSE_IRQ_EXTERNAL_M = {1'b1, 5'd11},
    EXC_CAUSE_IRQ_FAST_0     = {1'b1, 5'd16},
    EXC_CAUSE_IRQ_NM         = {1'b1, 5'd31}
  } exc_cause_e;
  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_REQ  = 2'd1,
    IRQ_NMI  = 2'd2
  } irq_ctrl_state_e;
  function automatic logic [5:0] irq_fast_cause(input logic [3:0] idx);
    return {1'b1, 5'd16 + {1'b0, idx}};
  endfunction
  // Returns the bit of v that backs a maskable cause; NMI and unknown causes map to 0.
  function automatic logic irq_cause_en(input irqs_t v, input logic [5:0] cause);
    return cause == EXC_CAUSE_IRQ_SOFTWARE_M ? v.irq_software :
           cause == EXC_CAUSE_IRQ_TIMER_M    ? v.irq_timer    :
           cause == EXC_CAUSE_IRQ_EXTERNAL_M ? v.irq_external :
           (cause[5:4] == 2'b11 && cause[3:0] != 4'hf) ? v.irq_fast[cause[3:0]] : 1'b0;
  endfunction
endpackage

// File: rtl/ibex_irq_prio_enc.sv
// ibex_irq_prio_enc: picks the highest-priority interrupt (NMI, fast 0..14, ext, sw, timer).
module ibex_irq_prio_enc
  import ibex_irq_ctrl_pkg::*;
(
  input  logic [17:0] irqs_i,
  input  logic        nmi_i,
  output logic        valid_o,
  output logic [5:0]  cause_o
);
  irqs_t irqs;
  assign irqs    = irqs_i;
  assign valid_o = nmi_i | (|irqs_i);
  always_comb begin
    cause_o = irqs.irq_external ? EXC_CAUSE_IRQ_EXTERNAL_M :
              irqs.irq_software ? EXC_CAUSE_IRQ_SOFTWARE_M :
              irqs.irq_timer    ? EXC_CAUSE_IRQ_TIMER_M    : 6'h0;
    for (int i = 14; i >= 0; i--)
      if (irqs.irq_fast[i]) cause_o = irq_fast_cause(4'(i));
    if (nmi_i) cause_o = EXC_CAUSE_IRQ_NM;
  end
endmodule

// File: rtl/ibex_irq_ctrl.sv
// ibex_irq_ctrl: registers interrupt sources, detects NMI and presents a held request/cause.
module ibex_irq_ctrl
  import ibex_irq_ctrl_pkg::*;
#(
  parameter bit NmiEdge = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [17:0] irqs_i,
  input  logic        irq_nm_i,
  input  logic [17:0] mie_i,
  input  logic        mstatus_mie_i,
  input  logic [1:0]  priv_lvl_i,
  input  logic        debug_mode_i,
  input  logic        irq_ack_i,
  input  logic        nmi_mret_i,
  output logic        irq_req_o,
  output logic [5:0]  irq_cause_o,
  output logic [17:0] mip_o,
  output logic        irq_wake_o,
  output logic        nmi_mode_o
);
  irq_ctrl_state_e state_q, state_d;
  irqs_t           mip_q, en;
  logic            nm_q, nmi_pend_q, nmi_pend_d, nmi_pend, nmi_ack;
  logic            req_q, req_d, global_en, cand_valid;
  logic [5:0]      cause_q, cause_d, cand_cause;
  assign global_en  = (mstatus_mie_i | (priv_lvl_i != PRIV_LVL_M)) & ~debug_mode_i;
  assign en         = mip_q & mie_i;
  assign nmi_pend   = NmiEdge ? nmi_pend_q : nm_q;
  assign nmi_ack    = irq_ack_i & (state_q == IRQ_REQ) & (cause_q == EXC_CAUSE_IRQ_NM);
  // A new edge in the acknowledging cycle must survive the clear.
  assign nmi_pend_d = (irq_nm_i & ~nm_q) | (nmi_pend_q & ~nmi_ack);
  ibex_irq_prio_enc u_prio_enc (
    .irqs_i  (global_en ? en : '0),
    .nmi_i   (nmi_pend & ~debug_mode_i),
    .valid_o (cand_valid),
    .cause_o (cand_cause)
  );
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cause_d = cause_q;
    unique case (state_q)
      IRQ_IDLE: if (cand_valid) begin
        state_d = IRQ_REQ;
        req_d   = 1'b1;
        cause_d = cand_cause;
      end
      IRQ_REQ: if (irq_ack_i) begin
        state_d = cause_q == EXC_CAUSE_IRQ_NM ? IRQ_NMI : IRQ_IDLE;
        req_d   = 1'b0;
      end else if (cause_q != EXC_CAUSE_IRQ_NM && !(global_en && irq_cause_en(en, cause_q))) begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
      IRQ_NMI: state_d = nmi_mret_i ? IRQ_IDLE : IRQ_NMI;
      default: begin
        state_d = IRQ_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IRQ_IDLE;
      mip_q      <= '0;
      nm_q       <= 1'b0;
      nmi_pend_q <= 1'b0;
      req_q      <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      mip_q      <= irqs_i;
      nm_q       <= irq_nm_i;
      nmi_pend_q <= nmi_pend_d;
      req_q      <= req_d;
      cause_q    <= cause_d;
    end
  end
  assign irq_req_o   = req_q;
  assign irq_cause_o = cause_q;
  assign mip_o       = mip_q;
  assign irq_wake_o  = (|en) | nmi_pend;
  assign nmi_mode_o  = state_q == IRQ_NMI;
  a_ack_in_req : assert property (@(posedge clk_i) disable iff (!rst_ni) irq_ack_i |-> state_q == IRQ_REQ);
endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// tb_ibex_irq_ctrl: cycle-by-cycle vector table plus reset and mask sequences.
module tb_ibex_irq_ctrl;
  typedef struct {
    logic [17:0] irqs;
    logic        nm;
    logic        gie;
    logic        dbg;
    logic        ack;
    logic        mret;
    logic        req;
    logic [5:0]  cause;
    logic        wake;
    logic        nmode;
  } vec_t;
  localparam logic [17:0] T   = 18'h10000;
  localparam logic [17:0] SW  = 18'h20000;
  localparam logic [17:0] EXT = 18'h08000;
  localparam logic [17:0] F0  = 18'h00001;
  localparam logic [17:0] F3  = 18'h00008;
  localparam logic [17:0] M   = 18'h3ffff;
  logic        clk = 1'b0, rst_ni = 1'b0;
  logic [17:0] irqs = '0, mie = M;
  logic        nm = 0, gie = 0, dbg = 0, ack = 0, mret = 0;
  logic        req, wake, nmode;
  logic [5:0]  cause;
  logic [17:0] mip;
  int          checks = 0, errors = 0;
  vec_t        v[27];
  ibex_irq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .irqs_i(irqs), .irq_nm_i(nm), .mie_i(mie),
    .mstatus_mie_i(gie), .priv_lvl_i(2'b11), .debug_mode_i(dbg), .irq_ack_i(ack),
    .nmi_mret_i(mret), .irq_req_o(req), .irq_cause_o(cause), .mip_o(mip),
    .irq_wake_o(wake), .nmi_mode_o(nmode)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic check_all(input string tag, input logic r, input logic [5:0] c, input logic w, input logic n);
    check({tag, " req"}, 32'(req), 32'(r));
    check({tag, " cause"}, 32'(cause), 32'(c));
    check({tag, " wake"}, 32'(wake), 32'(w));
    check({tag, " nmode"}, 32'(nmode), 32'(n));
  endtask
  task automatic step(input logic [17:0] i, input logic g, input logic [17:0] m);
    @(negedge clk);
    irqs = i; gie = g; mie = m; nm = 0; dbg = 0; ack = 0; mret = 0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    //        irqs     nm gie dbg ack mret | req cause  wake nmode
    v[0]  = '{T,       0, 1,  0,  0,  0,    0, 6'h00, 1, 0};
    v[1]  = '{T,       0, 1,  0,  0,  0,    1, 6'h27, 1, 0};
    v[2]  = '{0,       0, 1,  0,  1,  0,    0, 6'h27, 0, 0};
    v[3]  = '{0,       0, 1,  0,  0,  0,    0, 6'h27, 0, 0};
    v[4]  = '{F3|EXT,  0, 1,  0,  0,  0,    0, 6'h27, 1, 0};
    v[5]  = '{F3|EXT,  0, 1,  0,  0,  0,    1, 6'h33, 1, 0};
    v[6]  = '{EXT,     0, 1,  0,  1,  0,    0, 6'h33, 1, 0};
    v[7]  = '{EXT,     0, 1,  0,  0,  0,    1, 6'h2b, 1, 0};
    v[8]  = '{EXT|F0,  0, 1,  0,  0,  0,    1, 6'h2b, 1, 0};
    v[9]  = '{EXT|F0,  0, 1,  0,  0,  0,    1, 6'h2b, 1, 0};
    v[10] = '{EXT|F0,  0, 0,  0,  0,  0,    0, 6'h2b, 1, 0};
    v[11] = '{0,       0, 0,  0,  0,  0,    0, 6'h2b, 0, 0};
    v[12] = '{0,       0, 1,  0,  0,  0,    0, 6'h2b, 0, 0};
    v[13] = '{T,       1, 0,  0,  0,  0,    0, 6'h2b, 1, 0};
    v[14] = '{T,       0, 0,  0,  0,  0,    1, 6'h3f, 1, 0};
    v[15] = '{T,       0, 0,  0,  0,  0,    1, 6'h3f, 1, 0};
    v[16] = '{T,       0, 0,  0,  1,  0,    0, 6'h3f, 1, 1};
    v[17] = '{T,       0, 1,  0,  0,  0,    0, 6'h3f, 1, 1};
    v[18] = '{T,       0, 1,  0,  0,  1,    0, 6'h3f, 1, 0};
    v[19] = '{T,       0, 1,  0,  0,  0,    1, 6'h27, 1, 0};
    v[20] = '{0,       0, 1,  0,  1,  0,    0, 6'h27, 0, 0};
    v[21] = '{SW,      0, 0,  0,  0,  0,    0, 6'h27, 1, 0};
    v[22] = '{SW,      0, 0,  0,  0,  0,    0, 6'h27, 1, 0};
    v[23] = '{SW,      1, 1,  1,  0,  0,    0, 6'h27, 1, 0};
    v[24] = '{SW,      1, 1,  1,  0,  0,    0, 6'h27, 1, 0};
    v[25] = '{SW,      1, 1,  1,  0,  0,    0, 6'h27, 1, 0};
    v[26] = '{SW,      0, 1,  0,  0,  0,    1, 6'h3f, 1, 0};
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 6'h00, 0, 0);
    check("reset mip", 32'(mip), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      irqs = v[i].irqs; nm = v[i].nm; gie = v[i].gie; dbg = v[i].dbg;
      ack = v[i].ack; mret = v[i].mret; mie = M;
      @(posedge clk);
      #1;
      check_all($sformatf("row%0d", i), v[i].req, v[i].cause, v[i].wake, v[i].nmode);
    end
    // Asynchronous reset while an NMI request is outstanding.
    @(negedge clk);
    irqs = '0; nm = 0; dbg = 0; ack = 0;
    rst_ni = 1'b0;
    #1;
    check_all("async rst", 0, 6'h00, 0, 0);
    check("async rst mip", 32'(mip), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step('0, 1, M);
      check($sformatf("post rst req%0d", i), 32'(req), 0);
    end
    // Masked timer: no wake or request until its enable is set, then withdrawn on mask clear.
    step(T, 1, '0);
    step(T, 1, '0);
    check("masked req", 32'(req), 0);
    check("masked wake", 32'(wake), 0);
    step(T, 1, M);
    check("unmask req", 32'(req), 1);
    check("unmask cause", 32'(cause), 32'h27);
    check("unmask wake", 32'(wake), 1);
    step(T, 1, '0);
    check("mask withdraw req", 32'(req), 0);
    step('0, 1, M);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
